// File: rtl/mem_1rw_march_bist.sv
// March C- BIST initiator for a 1RW memory wrapper: issues one op per cycle,
// compares read data one cycle later and records the first failing read.
module mem_1rw_march_bist #(
    parameter int ELS    = 64,
    parameter int WIDTH  = 96,
    parameter int ADDR_W = $clog2(ELS)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    output logic              mem_v_o,
    output logic              mem_w_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [WIDTH-1:0]  mem_data_o,
    output logic [WIDTH-1:0]  mem_w_mask_o,
    input  logic [WIDTH-1:0]  mem_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [2:0]        fail_elem_o,
    output logic [ADDR_W-1:0] fail_addr_o,
    output logic [WIDTH-1:0]  fail_data_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ELS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [2:0]          elem;
    logic [2:0]          elem_n;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W-1:0]   addr_n;
    logic                phase;
    logic                phase_n;

    logic                rd_v;
    logic [2:0]          rd_elem;
    logic [ADDR_W-1:0]   rd_addr;
    logic                rd_bg;

    logic                run;
    logic                rw_elem;
    logic                down;
    logic                is_write;
    logic                addr_step;
    logic                at_end;
    logic                wr_bg;
    logic                rd_bg_n;
    logic                mismatch;
    logic                launch;

    // Element decode: elements 1..4 alternate read (phase 0) and write (phase 1).
    always_comb begin
        run       = (state == RUN);
        rw_elem   = (elem >= 3'd1) && (elem <= 3'd4);
        down      = (elem == 3'd3) || (elem == 3'd4);
        is_write  = (elem == 3'd0) || (rw_elem && phase);
        addr_step = !rw_elem || phase;
        at_end    = down ? (addr == '0) : (addr == LAST_ADDR);
        wr_bg     = (elem == 3'd1) || (elem == 3'd3);
        rd_bg_n   = (elem == 3'd2) || (elem == 3'd4);
        mismatch  = rd_v && ((state == RUN) || (state == DRAIN))
                    && (mem_data_i != {WIDTH{rd_bg}});
        launch    = start_i && ((state == IDLE) || (state == DONE));
    end

    always_comb begin
        state_n = state;
        elem_n  = elem;
        addr_n  = addr;
        phase_n = phase;
        case (state)
            IDLE, DONE: begin
                if (launch) begin
                    state_n = RUN;
                    elem_n  = '0;
                    addr_n  = '0;
                    phase_n = 1'b0;
                end
            end
            RUN: begin
                if (mismatch) begin
                    state_n = DONE;
                end else begin
                    if (rw_elem) begin
                        phase_n = !phase;
                    end
                    if (addr_step) begin
                        if (at_end) begin
                            if (elem == 3'd5) begin
                                state_n = DRAIN;
                            end else begin
                                elem_n = elem + 3'd1;
                                // Elements 3 and 4 walk downward from the top address.
                                addr_n = ((elem == 3'd2) || (elem == 3'd3)) ? LAST_ADDR : '0;
                            end
                        end else begin
                            addr_n = down ? (addr - ADDR_ONE) : (addr + ADDR_ONE);
                        end
                    end
                end
            end
            DRAIN: begin
                state_n = DONE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            elem  <= '0;
            addr  <= '0;
            phase <= 1'b0;
        end else begin
            elem  <= elem_n;
            addr  <= addr_n;
            phase <= phase_n;
        end
    end

    // Tag of the read in flight; compared against mem_data_i in the following cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_v    <= 1'b0;
            rd_elem <= '0;
            rd_addr <= '0;
            rd_bg   <= 1'b0;
        end else begin
            rd_v    <= run && !is_write;
            rd_elem <= elem;
            rd_addr <= addr;
            rd_bg   <= rd_bg_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pass_o      <= 1'b0;
            fail_elem_o <= '0;
            fail_addr_o <= '0;
            fail_data_o <= '0;
        end else if (launch) begin
            pass_o      <= 1'b0;
            fail_elem_o <= '0;
            fail_addr_o <= '0;
            fail_data_o <= '0;
        end else if (mismatch) begin
            fail_elem_o <= rd_elem;
            fail_addr_o <= rd_addr;
            fail_data_o <= mem_data_i;
        end else if (state == DRAIN) begin
            pass_o <= 1'b1;
        end
    end

    always_comb begin
        mem_v_o      = run;
        mem_w_o      = run && is_write;
        mem_addr_o   = run ? addr : '0;
        mem_data_o   = (run && is_write && wr_bg) ? '1 : '0;
        mem_w_mask_o = (run && is_write) ? '1 : '0;
        busy_o       = (state == RUN) || (state == DRAIN);
        done_o       = (state == DONE);
    end

endmodule

// File: tb/tb_mem_1rw_march_bist.sv
// Bench for mem_1rw_march_bist: 64-word and 48-word instances, each behind a
// behavioural memory with optional stuck-at faults; ops checked via a queue.
module tb_mem_1rw_march_bist;

    localparam int W  = 96;
    localparam int AW = 6;

    logic clk = 1'b0;
    logic reset;
    logic a_start, b_start;
    always #5 clk = ~clk;

    logic          a_v, a_w, a_busy, a_done, a_pass;
    logic [AW-1:0] a_addr, a_faddr;
    logic [W-1:0]  a_wdata, a_mask, a_rdata, a_fdata;
    logic [2:0]    a_felem;
    logic          b_v, b_w, b_busy, b_done, b_pass;
    logic [AW-1:0] b_addr, b_faddr;
    logic [W-1:0]  b_wdata, b_mask, b_rdata, b_fdata;
    logic [2:0]    b_felem;

    mem_1rw_march_bist #(.ELS(64), .WIDTH(W)) dut_a (
        .clk_i(clk), .reset_i(reset), .start_i(a_start),
        .mem_v_o(a_v), .mem_w_o(a_w), .mem_addr_o(a_addr),
        .mem_data_o(a_wdata), .mem_w_mask_o(a_mask), .mem_data_i(a_rdata),
        .busy_o(a_busy), .done_o(a_done), .pass_o(a_pass),
        .fail_elem_o(a_felem), .fail_addr_o(a_faddr), .fail_data_o(a_fdata)
    );

    mem_1rw_march_bist #(.ELS(48), .WIDTH(W)) dut_b (
        .clk_i(clk), .reset_i(reset), .start_i(b_start),
        .mem_v_o(b_v), .mem_w_o(b_w), .mem_addr_o(b_addr),
        .mem_data_o(b_wdata), .mem_w_mask_o(b_mask), .mem_data_i(b_rdata),
        .busy_o(b_busy), .done_o(b_done), .pass_o(b_pass),
        .fail_elem_o(b_felem), .fail_addr_o(b_faddr), .fail_data_o(b_fdata)
    );

    // Behavioural memories; the fault is applied to read data at f_addr.
    logic [AW-1:0] f_addr;
    logic [W-1:0]  f_sa1, f_sa0;
    logic [W-1:0]  mem_a [64];
    logic [W-1:0]  mem_b [48];

    function automatic logic [W-1:0] faulty(input logic [W-1:0] d, input logic [AW-1:0] a);
        if (a == f_addr) return (d | f_sa1) & ~f_sa0;
        return d;
    endfunction

    always @(posedge clk) begin
        if (a_v) begin
            if (a_w) mem_a[a_addr] <= (mem_a[a_addr] & ~a_mask) | (a_wdata & a_mask);
            else     a_rdata <= faulty(mem_a[a_addr], a_addr);
        end
        if (b_v) begin
            if (b_w) mem_b[b_addr] <= (mem_b[b_addr] & ~b_mask) | (b_wdata & b_mask);
            else     b_rdata <= faulty(mem_b[b_addr], b_addr);
        end
    end

    // Selected-instance view used by the shared tasks.
    logic          sel;
    logic          v, w, busy, done, pass;
    logic [AW-1:0] addr, faddr;
    logic [W-1:0]  wdata, mask, fdata;
    logic [2:0]    felem;
    always_comb begin
        v     = sel ? b_v     : a_v;
        w     = sel ? b_w     : a_w;
        busy  = sel ? b_busy  : a_busy;
        done  = sel ? b_done  : a_done;
        pass  = sel ? b_pass  : a_pass;
        addr  = sel ? b_addr  : a_addr;
        faddr = sel ? b_faddr : a_faddr;
        wdata = sel ? b_wdata : a_wdata;
        mask  = sel ? b_mask  : a_mask;
        fdata = sel ? b_fdata : a_fdata;
        felem = sel ? b_felem : a_felem;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic          w;
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
        logic [W-1:0]  mask;
    } op_t;
    op_t exp_q[$];

    task automatic push_op(input logic wr, input int a, input logic bg, input int limit);
        op_t o;
        if (exp_q.size() < limit) begin
            o.w    = wr;
            o.addr = AW'(a);
            o.data = (wr && bg) ? '1 : '0;
            o.mask = wr ? '1 : '0;
            exp_q.push_back(o);
        end
    endtask

    // March C- op stream, truncated after 'limit' ops.
    task automatic gen_ops(input int els, input int limit);
        exp_q.delete();
        for (int a = 0; a < els; a++) push_op(1'b1, a, 1'b0, limit);
        for (int a = 0; a < els; a++) begin push_op(1'b0, a, 1'b0, limit); push_op(1'b1, a, 1'b1, limit); end
        for (int a = 0; a < els; a++) begin push_op(1'b0, a, 1'b0, limit); push_op(1'b1, a, 1'b0, limit); end
        for (int a = els - 1; a >= 0; a--) begin push_op(1'b0, a, 1'b0, limit); push_op(1'b1, a, 1'b1, limit); end
        for (int a = els - 1; a >= 0; a--) begin push_op(1'b0, a, 1'b0, limit); push_op(1'b1, a, 1'b0, limit); end
        for (int a = 0; a < els; a++) push_op(1'b0, a, 1'b0, limit);
    endtask

    // Pulses start, then pops one expected op per cycle with mem_v_o high.
    task automatic run(input bit s, input int restart_at, input int abort_at,
                       output int done_k, output int max_addr);
        bit ovl;
        op_t e;
        sel = s;
        done_k = 0;
        max_addr = 0;
        ovl = 1'b0;
        @(negedge clk);
        if (s) b_start = 1'b1; else a_start = 1'b1;
        for (int k = 1; k <= 660; k++) begin
            @(negedge clk);
            a_start = 1'b0;
            b_start = 1'b0;
            if (k == restart_at) begin
                if (s) b_start = 1'b1; else a_start = 1'b1;
            end
            if (k == 1) begin
                chk("start_clears_status", {done, pass, felem, faddr}, '0);
                chk("start_clears_fdata", fdata, '0);
            end
            if (busy && done) ovl = 1'b1;
            if (v) begin
                if (int'(addr) > max_addr) max_addr = int'(addr);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_op: cycle %0d got op w=%b addr=%0d expected no op", k, w, addr);
                end else begin
                    e = exp_q.pop_front();
                    if (w !== e.w || addr !== e.addr || wdata !== e.data || mask !== e.mask) begin
                        errors++;
                        $display("FAIL op_cycle%0d: got w=%b addr=%0d data=%h mask=%h expected w=%b addr=%0d data=%h mask=%h",
                                 k, w, addr, wdata, mask, e.w, e.addr, e.data, e.mask);
                    end
                end
            end
            if (k == abort_at) begin
                reset = 1'b1;
                break;
            end
            if (done) begin
                done_k = k;
                break;
            end
        end
        chk("busy_done_exclusive", W'(ovl), '0);
        if (abort_at == 0) chk("ops_remaining", W'(exp_q.size()), '0);
    endtask

    typedef struct {
        bit            s;
        int            els;
        logic [AW-1:0] fa;
        logic [W-1:0]  sa1;
        logic [W-1:0]  sa0;
        int            nops;
        int            kdone;
        bit            pass;
        logic [2:0]    elem;
        logic [AW-1:0] faddr;
        logic [W-1:0]  fdata;
        int            restart_at;
    } vec_t;
    vec_t tbl[6];

    initial begin
        int dk, ma;
        logic [W-1:0] b5, b95, b40;
        b5  = 96'd1 << 5;
        b95 = 96'd1 << 95;
        b40 = 96'd1 << 40;

        tbl[0] = '{1'b0, 64, 6'd17, b5,   '0,     100, 101, 1'b0, 3'd1, 6'd17, b5,       0};
        tbl[1] = '{1'b0, 64, 6'd0,  '0,   96'd1,  194, 195, 1'b0, 3'd2, 6'd0,  ~96'd1,   0};
        tbl[2] = '{1'b0, 64, 6'd63, b95,  '0,     192, 193, 1'b0, 3'd1, 6'd63, b95,      0};
        tbl[3] = '{1'b0, 64, 6'd63, '0,   b40,    320, 321, 1'b0, 3'd2, 6'd63, ~b40,     0};
        tbl[4] = '{1'b0, 64, 6'd0,  '0,   '0,     640, 642, 1'b1, 3'd0, 6'd0,  '0,       0};
        tbl[5] = '{1'b1, 48, 6'd0,  '0,   '0,     480, 482, 1'b1, 3'd0, 6'd0,  '0,     100};

        reset = 1'b1;
        a_start = 1'b0;
        b_start = 1'b0;
        sel = 1'b0;
        f_addr = '0;
        f_sa1 = '0;
        f_sa0 = '0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl_a", {a_v, a_w, a_busy, a_done, a_pass, a_felem, a_faddr, a_addr}, '0);
        chk("reset_data_a", a_wdata | a_mask | a_fdata, '0);
        chk("reset_ctrl_b", {b_v, b_w, b_busy, b_done, b_pass, b_felem, b_faddr, b_addr}, '0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_no_op", {a_v, b_v, a_done, b_done}, '0);

        for (int i = 0; i < 6; i++) begin
            f_addr = tbl[i].fa;
            f_sa1  = tbl[i].sa1;
            f_sa0  = tbl[i].sa0;
            gen_ops(tbl[i].els, tbl[i].nops);
            run(tbl[i].s, tbl[i].restart_at, 0, dk, ma);
            chk($sformatf("case%0d_done_cycle", i), W'(dk), W'(tbl[i].kdone));
            chk($sformatf("case%0d_pass", i), W'(pass), W'(tbl[i].pass));
            chk($sformatf("case%0d_fail_elem", i), W'(felem), W'(tbl[i].elem));
            chk($sformatf("case%0d_fail_addr", i), W'(faddr), W'(tbl[i].faddr));
            chk($sformatf("case%0d_fail_data", i), fdata, tbl[i].fdata);
            chk($sformatf("case%0d_max_addr_in_range", i), W'(ma < tbl[i].els), W'(1));
            @(negedge clk);
            chk($sformatf("case%0d_done_held", i), {done, busy, v}, 96'b100);
        end

        // Reset in the 200th RUN cycle, then a full clean run.
        sel = 1'b0;
        f_sa1 = '0;
        f_sa0 = '0;
        gen_ops(64, 640);
        run(1'b0, 0, 200, dk, ma);
        @(negedge clk);
        chk("abort_idle", {a_v, a_busy, a_done, a_pass}, '0);
        chk("abort_status", {a_felem, a_faddr}, '0);
        reset = 1'b0;
        @(negedge clk);
        gen_ops(64, 640);
        run(1'b0, 0, 0, dk, ma);
        chk("rerun_done_cycle", W'(dk), W'(642));
        chk("rerun_pass", W'(a_pass), W'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
